// File: rtl/uart_rx_engine_if.sv
// Serial-line and CPU-side signal bundle for the UART receive engine.
// The master side drives the line, the frame configuration and the read strobe.
`timescale 1ns/1ps
interface uart_rx_engine_if;
    logic       RX;
    logic       EIGHT;
    logic       PEN;
    logic       OHEL;
    logic       READ_0;
    logic [7:0] UART_RDATA;
    logic       RXRDY;
    logic       PERR;
    logic       FERR;
    logic       OVF;

    modport master (
        output RX, EIGHT, PEN, OHEL, READ_0,
        input  UART_RDATA, RXRDY, PERR, FERR, OVF
    );

    modport slave (
        input  RX, EIGHT, PEN, OHEL, READ_0,
        output UART_RDATA, RXRDY, PERR, FERR, OVF
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes RX, validates the start bit, samples mid-bit,
// assembles a 7/8-bit word and reports parity, framing and overflow status.
`timescale 1ns/1ps
module uart_rx_engine #(
    parameter int BIT_TIME = 10417,
    parameter int CNT_W    = 14
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_engine_if.slave io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(BIT_TIME / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(BIT_TIME - 1);

    logic             sync_r;
    logic             rxs_r;
    logic             rxs_prev_r;
    state_t           state_r;
    logic [CNT_W-1:0] bt_cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [9:0]       shift_r;
    logic             eight_r;
    logic             pen_r;
    logic             ohel_r;
    logic             done_r;

    logic             fall_s;
    logic [3:0]       frame_len_s;
    logic [3:0]       shift_amt_s;
    logic [8:0]       aligned_s;
    logic [7:0]       data_s;
    logic             par_s;
    logic             perr_next_s;
    logic             ferr_next_s;

    // Expected parity bit for a data word: even parity when odd=0, odd parity when odd=1
    function automatic logic parity_expected(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Two-flop synchronizer plus previous-sample flop, preset high so release is not a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r     <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            sync_r     <= io.RX;
            rxs_r      <= sync_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Frame length from latched config and word extraction from the right-shifted samples
    always_comb begin
        fall_s      = rxs_prev_r & ~rxs_r;
        frame_len_s = (eight_r ? 4'd8 : 4'd7) + {3'b000, pen_r} + 4'd1;
        shift_amt_s = 4'd10 - frame_len_s;
        aligned_s   = 9'(shift_r >> shift_amt_s);
        if (eight_r) begin
            data_s = aligned_s[7:0];
            par_s  = aligned_s[8];
        end else begin
            data_s = {1'b0, aligned_s[6:0]};
            par_s  = aligned_s[7];
        end
        perr_next_s = pen_r & (par_s != parity_expected(data_s, ohel_r));
        ferr_next_s = ~shift_r[9];
    end

    // Receive FSM: start detection, half-bit validation, mid-bit sampling, done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            bt_cnt_r  <= '0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 10'd0;
            eight_r   <= 1'b0;
            pen_r     <= 1'b0;
            ohel_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r   <= START;
                        bt_cnt_r  <= '0;
                        bit_cnt_r <= 4'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (bt_cnt_r == HALF_TC) begin
                        bt_cnt_r <= '0;
                        if (!rxs_r) begin
                            state_r <= DATA;
                            eight_r <= io.EIGHT;
                            pen_r   <= io.PEN;
                            ohel_r  <= io.OHEL;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        bt_cnt_r <= bt_cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bt_cnt_r == FULL_TC) begin
                        bt_cnt_r  <= '0;
                        shift_r   <= {rxs_r, shift_r[9:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        // The stop sample is the Nth one; hand the frame to the output stage
                        if ((bit_cnt_r + 4'd1) == frame_len_s) begin
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        bt_cnt_r <= bt_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output register: a completed frame takes priority over a simultaneous read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io.UART_RDATA <= 8'd0;
            io.RXRDY      <= 1'b0;
            io.PERR       <= 1'b0;
            io.FERR       <= 1'b0;
            io.OVF        <= 1'b0;
        end else if (done_r) begin
            io.UART_RDATA <= data_s;
            io.RXRDY      <= 1'b1;
            io.PERR       <= perr_next_s;
            io.FERR       <= ferr_next_s;
            io.OVF        <= io.RXRDY;
        end else if (io.READ_0) begin
            io.RXRDY <= 1'b0;
            io.PERR  <= 1'b0;
            io.FERR  <= 1'b0;
            io.OVF   <= 1'b0;
        end else begin
            io.RXRDY <= io.RXRDY;
        end
    end

endmodule
